hack_gate_flag_unit: RTL and testbench

// - Registered gate-level logic and status-flag stage for the Hack ALU datapath.
// - Built from the basic gates: NOT (bitwise), AND2 (bitwise) and OR8 (byte reduction).
// - Outputs bitwise NOT of operand a, bitwise AND of a and b, per-byte OR reductions,

---
 rtl/hack_gate_flag_unit.sv | 78 +++++++
 tb/tb_hack_gate_flag_unit.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/hack_gate_flag_unit.sv
// Registered NOT / AND2 / OR8 gate banks with zero and negative status flags for the Hack ALU.
// Optional sticky zero flag enabled by defining STICKY_ZR_EN.
module hack_gate_flag_unit #(
  parameter int unsigned WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 clr_flag,
  output logic                 out_valid,
  output logic [WIDTH-1:0]     not_a,
  output logic [WIDTH-1:0]     and_ab,
  output logic [WIDTH/8-1:0]   or8,
  output logic                 zr,
  output logic                 ng,
  output logic                 zr_sticky
);

  localparam int unsigned NBYTES = WIDTH / 8;

  logic [WIDTH-1:0]  not_d;
  logic [WIDTH-1:0]  and_d;
  logic [NBYTES-1:0] or8_d;
  logic              zr_d;
  logic              ng_d;

  // zr is built from the OR8 bank outputs rather than a separate wide reduction
  always_comb begin
    not_d = ~a;
    and_d = a & b;
    or8_d = '0;
    for (int unsigned k = 0; k < NBYTES; k++) begin
      or8_d[k] = |a[8*k +: 8];
    end
    zr_d = ~(|or8_d);
    ng_d = 1'b1 & a[WIDTH-1];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      not_a     <= '0;
      and_ab    <= '0;
      or8       <= '0;
      zr        <= 1'b0;
      ng        <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        not_a  <= not_d;
        and_ab <= and_d;
        or8    <= or8_d;
        zr     <= zr_d;
        ng     <= ng_d;
      end
    end
  end

`ifdef STICKY_ZR_EN
  // A valid zero input takes priority over a simultaneous clear
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      zr_sticky <= 1'b0;
    end else if (in_valid && zr_d) begin
      zr_sticky <= 1'b1;
    end else if (clr_flag) begin
      zr_sticky <= 1'b0;
    end
  end
`else
  logic unused_clr_flag;
  assign unused_clr_flag = clr_flag;
  assign zr_sticky       = 1'b0;
`endif

endmodule

// File: tb/tb_hack_gate_flag_unit.sv
// Self-checking bench for hack_gate_flag_unit: directed vector table, sticky-flag sequence,
// and randomized stimulus against an arithmetic reference model.
`timescale 1ns/1ps
module tb_hack_gate_flag_unit;

  localparam int unsigned W = 16;
`ifdef STICKY_ZR_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic          clr_flag;
  logic          out_valid;
  logic [W-1:0]  not_a;
  logic [W-1:0]  and_ab;
  logic [W/8-1:0] or8;
  logic          zr;
  logic          ng;
  logic          zr_sticky;

  hack_gate_flag_unit #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .clr_flag  (clr_flag),
    .out_valid (out_valid),
    .not_a     (not_a),
    .and_ab    (and_ab),
    .or8       (or8),
    .zr        (zr),
    .ng        (ng),
    .zr_sticky (zr_sticky)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // reference model state
  int unsigned m_valid, m_not, m_and, m_or8, m_zr, m_ng, m_sticky;

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_edge(input bit r, input bit v, input int unsigned av,
                            input int unsigned bv, input bit c);
    int unsigned s;
    if (!r) begin
      m_valid = 0; m_not = 0; m_and = 0; m_or8 = 0; m_zr = 0; m_ng = 0; m_sticky = 0;
    end else begin
      m_valid = v;
      if (v) begin
        m_not = 65535 - av;
        s = 0;
        for (int i = 0; i < 16; i++)
          if (((av >> i) % 2 == 1) && ((bv >> i) % 2 == 1)) s += (1 << i);
        m_and = s;
        m_or8 = ((av % 256) != 0 ? 1 : 0) + ((av / 256) != 0 ? 2 : 0);
        m_zr  = (av == 0) ? 1 : 0;
        m_ng  = (av >= 32768) ? 1 : 0;
      end
      if (STICKY) begin
        if (v && av == 0) m_sticky = 1;
        else if (c)       m_sticky = 0;
      end
    end
  endtask

  // Drive one cycle's inputs, clock, then compare every output with the model.
  task automatic step(input bit r, input bit v, input logic [W-1:0] av,
                      input logic [W-1:0] bv, input bit c);
    rst_n = r; in_valid = v; a = av; b = bv; clr_flag = c;
    @(posedge clk);
    #1;
    model_edge(r, v, av, bv, c);
    check("mdl_out_valid", out_valid, m_valid);
    check("mdl_not_a",     not_a,     m_not);
    check("mdl_and_ab",    and_ab,    m_and);
    check("mdl_or8",       or8,       m_or8);
    check("mdl_zr",        zr,        m_zr);
    check("mdl_ng",        ng,        m_ng);
    check("mdl_zr_sticky", zr_sticky, m_sticky);
  endtask

  typedef struct {
    bit          r;
    bit          v;
    logic [15:0] av;
    logic [15:0] bv;
    bit          ov;
    logic [15:0] nt;
    logic [15:0] an;
    logic [1:0]  o8;
    bit          z;
    bit          n;
  } vec_t;

  vec_t tbl [11];

  initial begin
    tbl[0]  = '{1'b0, 1'b1, 16'hFFFF, 16'hFFFF, 1'b0, 16'h0000, 16'h0000, 2'b00, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 1'b1, 16'hFFFF, 16'hFFFF, 1'b0, 16'h0000, 16'h0000, 2'b00, 1'b0, 1'b0};
    tbl[2]  = '{1'b1, 1'b1, 16'h0000, 16'hFFFF, 1'b1, 16'hFFFF, 16'h0000, 2'b00, 1'b1, 1'b0};
    tbl[3]  = '{1'b1, 1'b1, 16'h1672, 16'h01C9, 1'b1, 16'hE98D, 16'h0040, 2'b11, 1'b0, 1'b0};
    tbl[4]  = '{1'b1, 1'b1, 16'h8000, 16'h1234, 1'b1, 16'h7FFF, 16'h0000, 2'b10, 1'b0, 1'b1};
    tbl[5]  = '{1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h7FFF, 16'h0000, 2'b10, 1'b0, 1'b1};
    tbl[6]  = '{1'b1, 1'b0, 16'h00FF, 16'hFFFF, 1'b0, 16'h7FFF, 16'h0000, 2'b10, 1'b0, 1'b1};
    tbl[7]  = '{1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h7FFF, 16'h0000, 2'b10, 1'b0, 1'b1};
    tbl[8]  = '{1'b1, 1'b1, 16'h0001, 16'hFFFF, 1'b1, 16'hFFFE, 16'h0001, 2'b01, 1'b0, 1'b0};
    tbl[9]  = '{1'b1, 1'b1, 16'h0100, 16'hFFFF, 1'b1, 16'hFEFF, 16'h0100, 2'b10, 1'b0, 1'b0};
    tbl[10] = '{1'b1, 1'b1, 16'hFFFF, 16'hFFFF, 1'b1, 16'h0000, 16'hFFFF, 2'b11, 1'b0, 1'b1};

    rst_n = 1'b0; in_valid = 1'b1; a = 16'hFFFF; b = 16'hFFFF; clr_flag = 1'b0;
    m_valid = 0; m_not = 0; m_and = 0; m_or8 = 0; m_zr = 0; m_ng = 0; m_sticky = 0;

    for (int i = 0; i < 11; i++) begin
      step(tbl[i].r, tbl[i].v, tbl[i].av, tbl[i].bv, 1'b0);
      check("tbl_out_valid", out_valid, tbl[i].ov);
      check("tbl_not_a",     not_a,     tbl[i].nt);
      check("tbl_and_ab",    and_ab,    tbl[i].an);
      check("tbl_or8",       or8,       tbl[i].o8);
      check("tbl_zr",        zr,        tbl[i].z);
      check("tbl_ng",        ng,        tbl[i].n);
    end

    // sticky zero flag: set, hold across nonzero, clear, set-wins-over-clear, reset
    step(1'b1, 1'b1, 16'h0000, 16'h0000, 1'b0);
    check("stk_set", zr_sticky, STICKY);
    step(1'b1, 1'b1, 16'h0005, 16'h0000, 1'b0);
    check("stk_hold_nonzero", zr_sticky, STICKY);
    check("stk_zr_live", zr, 0);
    step(1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0);
    check("stk_hold_idle", zr_sticky, STICKY);
    step(1'b1, 1'b0, 16'h0000, 16'h0000, 1'b1);
    check("stk_clear", zr_sticky, 0);
    step(1'b1, 1'b1, 16'h0000, 16'h0000, 1'b1);
    check("stk_set_wins", zr_sticky, STICKY);
    step(1'b0, 1'b1, 16'h0000, 16'h0000, 1'b0);
    check("stk_reset", zr_sticky, 0);
    check("stk_reset_valid", out_valid, 0);
    check("stk_reset_not_a", not_a, 0);

    // randomized stimulus with boundary-biased operands
    for (int i = 0; i < 400; i++) begin
      logic [W-1:0] ra;
      case ($urandom_range(0, 7))
        0:       ra = 16'h0000;
        1:       ra = 16'hFFFF;
        2:       ra = 16'h8000;
        3:       ra = 16'(1 << $urandom_range(0, 15));
        default: ra = 16'($urandom);
      endcase
      step($urandom_range(0, 24) != 0, $urandom_range(0, 3) != 0, ra, 16'($urandom),
           $urandom_range(0, 5) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
